// File: rtl/sa_tile_feeder_pkg.sv
// Shared definitions for the systolic-array tile feeder: default geometry,
// element type and controller state encoding.
package sa_tile_feeder_pkg;
  localparam int N_DEF  = 4;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef logic [DW_DEF-1:0] elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_STREAM,
    ST_DONE
  } feeder_state_e;
endpackage

// File: rtl/sa_tile_feeder_if.sv
// Operand RAM port plus skewed-beat stream toward the array edge.
// The feeder is the master; RAM and array together form the slave side.
interface sa_tile_feeder_if
  import sa_tile_feeder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_dout;
  logic            out_valid;
  logic            out_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_lane_vld;

  modport master (
    output mem_addr, mem_we, out_valid, out_data, out_lane_vld,
    input  mem_dout, out_ready
  );

  modport slave (
    input  mem_addr, mem_we, out_valid, out_data, out_lane_vld,
    output mem_dout, out_ready
  );
endinterface

// File: rtl/sa_tile_feeder_skew.sv
// Combinational diagonal skew: selects, for beat t, the element each lane
// presents (row-wise or column-wise) and flags lanes outside the diagonal.
module sa_skew_mux #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int TW = 3
) (
  input  logic [N*N*DW-1:0] tile,
  input  logic [TW-1:0]     t,
  input  logic              transpose,
  output logic [N*DW-1:0]   data,
  output logic [N-1:0]      lane_vld
);
  int d;

  always_comb begin
    data     = '0;
    lane_vld = '0;
    d        = 0;
    for (int k = 0; k < N; k++) begin
      d = int'(t) - k;
      if (d >= 0 && d < N) begin
        lane_vld[k] = 1'b1;
        if (transpose)
          data[k*DW +: DW] = tile[(d*N + k)*DW +: DW];
        else
          data[k*DW +: DW] = tile[(k*N + d)*DW +: DW];
      end
    end
  end
endmodule

// File: rtl/sa_tile_feeder.sv
// Loads one NxN tile from a single-port RAM into a local buffer, then streams
// it to the array edge as 2N-1 diagonally skewed beats with valid/ready flow.
module sa_tile_feeder
  import sa_tile_feeder_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic            transpose,
  output logic            busy,
  output logic            done,
  sa_tile_feeder_if.master bus
);
  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int TW = $clog2(2 * N);
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(2 * N - 2);

  feeder_state_e   state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   cidx;
  logic            cap;
  logic [TW-1:0]   t;
  logic            transpose_q;
  logic [AW-1:0]   mem_addr_q;
  logic            out_valid_q;
  logic [DW-1:0]   tile [NN];
  logic [NN*DW-1:0] tile_flat;
  logic [N*DW-1:0] mux_data;
  logic [N-1:0]    mux_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      idx         <= '0;
      t           <= '0;
      transpose_q <= 1'b0;
      cap         <= 1'b0;
    end else begin
      cap  <= (state == ST_FETCH);
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_FETCH;
            busy        <= 1'b1;
            mem_addr_q  <= base_addr;
            idx         <= '0;
            transpose_q <= transpose;
          end
        end
        ST_FETCH: begin
          if (idx == IDX_LAST) begin
            state <= ST_DRAIN;
          end else begin
            idx        <= idx + 1'b1;
            mem_addr_q <= mem_addr_q + 1'b1;
          end
        end
        // Read latency: the last word arrives during this cycle.
        ST_DRAIN: begin
          state       <= ST_STREAM;
          t           <= '0;
          out_valid_q <= 1'b1;
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (t == T_LAST) begin
              state       <= ST_DONE;
              out_valid_q <= 1'b0;
              done        <= 1'b1;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture side trails the address side by one cycle of RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cidx <= '0;
    else if (state == ST_IDLE && start)
      cidx <= '0;
    else if (cap)
      cidx <= cidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cap)
      tile[cidx] <= bus.mem_dout;
  end

  always_comb begin
    tile_flat = '0;
    for (int i = 0; i < NN; i++)
      tile_flat[i*DW +: DW] = tile[i];
  end

  sa_skew_mux #(.N(N), .DW(DW), .TW(TW)) u_skew (
    .tile      (tile_flat),
    .t         (t),
    .transpose (transpose_q),
    .data      (mux_data),
    .lane_vld  (mux_vld)
  );

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_we       = 1'b0;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_valid_q ? mux_data : '0;
  assign bus.out_lane_vld = out_valid_q ? mux_vld  : '0;
endmodule
